// File: rtl/spi_pkg.sv
`default_nettype none
// spi_pkg : shared state type and mode constants for the SPI target engine (rev 1.0)
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_TGT_IDLE   = 2'd0,
    SPI_TGT_SELECT = 2'd1,
    SPI_TGT_XFER   = 2'd2,
    SPI_TGT_WORD   = 2'd3
  } spi_tgt_state_t;

  // Mode encoding is {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// spi_sync_edge : N-stage synchronizer with registered level and rise/fall pulses (rev 1.0)
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              level_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain      <= {STAGES{RESET_VAL}};
      level      <= RESET_VAL;
      level_prev <= RESET_VAL;
    end else begin
      chain      <= {chain[STAGES-2:0], din};
      level      <= chain[STAGES-1];
      level_prev <= level;
    end
  end

  assign rise = level & ~level_prev;
  assign fall = ~level & level_prev;

endmodule
`default_nettype wire

// File: rtl/spi_target_fsm.sv
`default_nettype none
// spi_target_fsm : SPI target engine, all CPOL/CPHA modes, back-to-back words (rev 1.0)
// Optional sticky TX underrun flag enabled by `define SPI_TGT_UNDERRUN_EN
module spi_target_fsm
  import spi_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_en,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_data_valid,
  output logic              tx_data_ready,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_data_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int               CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  spi_tgt_state_t    state, next_state;
  logic              sclk_s, sclk_rise, sclk_fall;
  logic              cs_n_s, cs_rise_unused, cs_fall;
  logic              mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic              cpol_q, cpha_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] tx_shift, rx_shift;
  logic              leading, trailing, sample_edge, shift_edge;
  logic              abort, tx_load, last_sample;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs_n idles high, so its synchronizer resets high to avoid a false select
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .level(cs_n_s), .rise(cs_rise_unused), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign leading     = cpol_q ? sclk_fall : sclk_rise;
  assign trailing    = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trailing  : leading;
  assign shift_edge  = cpha_q ? leading   : trailing;
  assign abort       = cs_n_s | ~spi_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SPI_TGT_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    tx_load       = 1'b0;
    last_sample   = 1'b0;
    busy          = 1'b1;
    miso_oe       = 1'b0;
    rx_data_valid = 1'b0;
    case (state)
      SPI_TGT_IDLE: begin
        busy = 1'b0;
        if (spi_en && cs_fall) next_state = SPI_TGT_SELECT;
      end
      SPI_TGT_SELECT: begin
        miso_oe    = 1'b1;
        tx_load    = ~abort;
        next_state = abort ? SPI_TGT_IDLE : SPI_TGT_XFER;
      end
      SPI_TGT_XFER: begin
        miso_oe     = 1'b1;
        last_sample = ~abort & sample_edge & (bit_cnt == LAST_BIT);
        if (abort)            next_state = SPI_TGT_IDLE;
        else if (last_sample) next_state = SPI_TGT_WORD;
      end
      SPI_TGT_WORD: begin
        miso_oe       = 1'b1;
        rx_data_valid = 1'b1;
        tx_load       = ~abort;
        next_state    = abort ? SPI_TGT_IDLE : SPI_TGT_XFER;
      end
      default: next_state = SPI_TGT_IDLE;
    endcase
  end

  assign tx_data_ready = tx_load & tx_data_valid;
  assign miso          = miso_oe & tx_shift[WORD_W-1];

  // The first shift edge after a load only presents the freshly loaded MSB,
  // so shifting is suppressed until at least one bit of the word was sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (state == SPI_TGT_IDLE && next_state == SPI_TGT_SELECT) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
      end
      if (abort) begin
        bit_cnt <= '0;
      end else if (tx_load) begin
        bit_cnt  <= '0;
        tx_shift <= tx_data_valid ? tx_data : '0;
      end else if (state == SPI_TGT_XFER) begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[WORD_W-2:0], mosi_s};
          bit_cnt  <= bit_cnt + 1'b1;
        end
        if (shift_edge && bit_cnt != '0)
          tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
      end
      if (last_sample) rx_data <= {rx_shift[WORD_W-2:0], mosi_s};
    end
  end

`ifdef SPI_TGT_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         underrun_q <= 1'b0;
    else if (!spi_en)                   underrun_q <= 1'b0;
    else if (tx_load && !tx_data_valid) underrun_q <= 1'b1;
  end

  assign tx_underrun = underrun_q;
`else
  assign tx_underrun = 1'b0;
`endif

endmodule
`default_nettype wire
